// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 5-instruction ISA (LW, SW, R-type, BEQ, J).
// Latency: one state per clock; LW 5, SW/R 4, BEQ/J 3, illegal 2 cycles minimum.
// Backpressure: holds in FETCH / MEM_RD / MEM_WR while mem_ready is low.
module multicycle_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;

    localparam logic [5:0] OP_LW  = 6'b000000;
    localparam logic [5:0] OP_SW  = 6'b000001;
    localparam logic [5:0] OP_R   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000011;
    localparam logic [5:0] OP_J   = 6'b000100;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             retire;

    // State and retired-instruction counter; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state decode; retire marks the edge that leaves an instruction's final state.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;   // illegal: drop without retiring
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_R_WB;
            end
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // Encodings 10-15 are unreachable; recover to FETCH if one ever appears.
            default: state_d = S_FETCH;
        endcase
    end

    // Counter wraps naturally at 2^CNT_W.
    always_comb begin
        instr_count_d = instr_count_q;
        if (retire) instr_count_d = instr_count_q + CNT_W'(1);
    end

    // Moore outputs per state, plus the mem_ready-qualified FETCH loads and the DECODE illegal flag.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        // Reset gates everything combinationally so strobes drop without waiting for an edge.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;   // branch target precomputed into ALUOut
                    illegal_op = (opcode != OP_LW) && (opcode != OP_SW) && (opcode != OP_R) &&
                                 (opcode != OP_BEQ) && (opcode != OP_J);
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign pc_en       = pc_write | (pc_write_cond & zero);
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a queue-based scoreboard.
// Counter width is reduced so the wrap boundary is reachable in a short run.
module tb_multicycle_control_fsm;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        string            tag;
        logic [3:0]       st;
        ctl_t             ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]       pc_source, alu_src_b, alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    ctl_t             obs;
    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt;
    int               vectors;
    int               miscompares;

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    assign obs = {pc_write, pc_write_cond, pc_en, pc_source, iord, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    // Reference control word for a state, taken from the per-state output table.
    function automatic ctl_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                     input logic z, input logic mr, input logic in_rst);
        ctl_t c;
        c = '0;
        if (!in_rst) begin
            case (st)
                4'd0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
                4'd1: begin c.alu_src_b = 2'b11; c.illegal_op = (op > 6'd4); end
                4'd2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
                4'd3: begin c.mem_read = 1; c.iord = 1; end
                4'd4: begin c.reg_write = 1; c.mem_to_reg = 1; end
                4'd5: begin c.mem_write = 1; c.iord = 1; end
                4'd6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
                4'd7: begin c.reg_write = 1; c.reg_dst = 1; end
                4'd8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
                4'd9: begin c.pc_write = 1; c.pc_source = 2'b10; end
                default: ;
            endcase
            c.pc_en = c.pc_write | (c.pc_write_cond & z);
        end
        return c;
    endfunction

    task automatic push(input string tag, input logic [3:0] st, input logic in_rst);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ctl = exp_out(st, opcode, zero, mem_ready, in_rst);
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL scoreboard: observed empty queue, required an entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors += 3;
            assert (state === e.st) else begin
                miscompares++;
                $error("FAIL %s state: observed %0d required %0d", e.tag, state, e.st);
            end
            assert (obs === e.ctl) else begin
                miscompares++;
                $error("FAIL %s ctl (st %0d): observed %b required %b", e.tag, e.st, obs, e.ctl);
            end
            assert (instr_count === e.cnt) else begin
                miscompares++;
                $error("FAIL %s count (st %0d): observed %0d required %0d", e.tag, e.st, instr_count, e.cnt);
            end
        end
    endtask

    // One clock: drive inputs, expect state st, then cross the rising edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [5:0] op,
                       input logic z, input logic mr, input logic ret);
        opcode = op; zero = z; mem_ready = mr;
        push(tag, st, 1'b0);
        #1;
        pop_check();
        if (ret) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
    endtask

    task automatic do_j();
        cyc("J", 4'd0, 6'h3F, 0, 1, 0);
        cyc("J", 4'd1, 6'b000100, 0, 1, 0);
        cyc("J", 4'd9, 6'h2A, 0, 1, 1);
    endtask

    task automatic do_beq(input logic z);
        cyc("BEQ", 4'd0, 6'b000011, z, 1, 0);
        cyc("BEQ", 4'd1, 6'b000011, z, 1, 0);
        cyc("BEQ", 4'd8, 6'b000011, z, 1, 1);
    endtask

    initial begin
        vectors = 0; miscompares = 0; exp_cnt = '0;
        reset = 1'b1; opcode = 6'b000010; zero = 1'b0; mem_ready = 1'b1;

        // Reset: FETCH with every strobe and select held at zero.
        @(negedge clk);
        push("reset", 4'd0, 1'b1); #1; pop_check();
        @(negedge clk);
        reset = 1'b0;

        // R-type: 0,1,6,7; opcode garbage in EXEC must be ignored.
        cyc("R", 4'd0, 6'b000010, 0, 1, 0);
        cyc("R", 4'd1, 6'b000010, 0, 1, 0);
        cyc("R", 4'd6, 6'h3F,     0, 1, 0);
        cyc("R", 4'd7, 6'b000010, 0, 1, 1);

        // LW with three stall cycles in MEM_RD: 8 cycles total.
        cyc("LW", 4'd0, 6'b000000, 0, 1, 0);
        cyc("LW", 4'd1, 6'b000000, 0, 1, 0);
        cyc("LW", 4'd2, 6'b000000, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("LW", 4'd3, 6'b000000, 0, 0, 0);
        cyc("LW", 4'd3, 6'b000000, 0, 1, 0);
        cyc("LW", 4'd4, 6'b000000, 0, 1, 1);

        // SW with one FETCH stall and one MEM_WR stall.
        cyc("SW", 4'd0, 6'b000001, 0, 0, 0);
        cyc("SW", 4'd0, 6'b000001, 0, 1, 0);
        cyc("SW", 4'd1, 6'b000001, 0, 1, 0);
        cyc("SW", 4'd2, 6'b000001, 0, 1, 0);
        cyc("SW", 4'd5, 6'b000001, 0, 0, 0);
        cyc("SW", 4'd5, 6'b000001, 0, 1, 1);

        // BEQ taken and not taken both retire.
        do_beq(1'b1);
        do_beq(1'b0);

        // Illegal opcode: one-cycle flag in DECODE, back to FETCH, no retire.
        cyc("ILL", 4'd0, 6'b111111, 0, 1, 0);
        cyc("ILL", 4'd1, 6'b111111, 0, 1, 0);
        cyc("ILL", 4'd0, 6'b111111, 0, 0, 0);

        // Counter wrap: run jumps up to the maximum value, then one more.
        while (exp_cnt != {CNT_W{1'b1}}) do_j();
        do_j();
        cyc("WRAP", 4'd0, 6'b000100, 0, 0, 0);

        // Asynchronous reset in the middle of a stalled store.
        cyc("ARST", 4'd0, 6'b000001, 0, 1, 0);
        cyc("ARST", 4'd1, 6'b000001, 0, 1, 0);
        cyc("ARST", 4'd2, 6'b000001, 0, 1, 0);
        opcode = 6'b000001; mem_ready = 1'b0;
        push("ARST.pre", 4'd5, 1'b0); #1; pop_check();
        #1 reset = 1'b1;
        exp_cnt = '0;
        #1;
        push("ARST.async", 4'd0, 1'b1); pop_check();
        @(negedge clk);
        push("ARST.hold", 4'd0, 1'b1); #1; pop_check();
        @(negedge clk);
        reset = 1'b0;

        // First fetch after release proceeds normally.
        cyc("POST", 4'd0, 6'b000100, 0, 1, 0);
        cyc("POST", 4'd1, 6'b000100, 0, 1, 0);
        cyc("POST", 4'd9, 6'b000100, 0, 1, 1);
        cyc("POST", 4'd0, 6'b000100, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
